// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32 instruction decoder feeding a DEPTH-entry output FIFO
// Optional multiply/divide decode is enabled by defining DECODE_M_EXT_EN.
module decode_stage #(
  parameter int PC_WIDTH  = 32,
  parameter int DEPTH     = 2,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 Clock,
  input  logic                 Reset_n,
  input  logic                 Flush,
  input  logic                 InValid,
  output logic                 InReady,
  input  logic [31:0]          InInstruction,
  input  logic [PC_WIDTH-1:0]  InPC,
  output logic                 OutValid,
  input  logic                 OutReady,
  output logic [PC_WIDTH-1:0]  OutPC,
  output logic [4:0]           RD,
  output logic [4:0]           RS1,
  output logic [4:0]           RS2,
  output logic [31:0]          DecodedImmediate,
  output logic [1:0]           LHSsource,
  output logic [1:0]           RHSsource,
  output logic [4:0]           ALUOperation,
  output logic                 WritesRegisterFile,
  output logic                 WritesRam,
  output logic                 ReadsRam,
  output logic                 IsBranch,
  output logic                 IsJump,
  output logic [2:0]           MemSize,
  output logic                 InvalidInstructionSignal,
  output logic [CNT_WIDTH-1:0] IllegalCount
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [PC_WIDTH-1:0] pc;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [31:0]         imm;
    logic [1:0]          lhs;
    logic [1:0]          rhs;
    logic [4:0]          alu;
    logic                wrf;
    logic                wram;
    logic                rram;
    logic                br;
    logic                jmp;
    logic [2:0]          msize;
    logic                ill;
  } bundle_t;

  bundle_t        dec;
  bundle_t        shown;
  bundle_t        last_q;
  bundle_t        mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic           push;
  logic           pop;

  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign f3    = InInstruction[14:12];
  assign f7    = InInstruction[31:25];
  assign imm_i = {{20{InInstruction[31]}}, InInstruction[31:20]};
  assign imm_s = {{20{InInstruction[31]}}, InInstruction[31:25], InInstruction[11:7]};
  assign imm_b = {{19{InInstruction[31]}}, InInstruction[31], InInstruction[7],
                  InInstruction[30:25], InInstruction[11:8], 1'b0};
  assign imm_u = {InInstruction[31:12], 12'b0};
  assign imm_j = {{11{InInstruction[31]}}, InInstruction[31], InInstruction[19:12],
                  InInstruction[20], InInstruction[30:21], 1'b0};

  // Unknown opcodes fall through with ill still set.
  always_comb begin
    dec     = '0;
    dec.pc  = InPC;
    dec.rd  = InInstruction[11:7];
    dec.rs1 = InInstruction[19:15];
    dec.rs2 = InInstruction[24:20];
    dec.ill = 1'b1;
    case (InInstruction[6:0])
      7'b0010011: begin
        dec.ill = 1'b0;
        dec.imm = imm_i;
        dec.rhs = 2'd1;
        dec.wrf = 1'b1;
        dec.alu = {1'b0, (f3 == 3'b101) & InInstruction[30], f3};
        if (f3 == 3'b001 && f7 != 7'b0000000)
          dec.ill = 1'b1;
        if (f3 == 3'b101 && f7 != 7'b0000000 && f7 != 7'b0100000)
          dec.ill = 1'b1;
      end
      7'b0110011: begin
        dec.wrf = 1'b1;
        dec.alu = {1'b0, InInstruction[30], f3};
        if (f7 == 7'b0000000 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)))
          dec.ill = 1'b0;
`ifdef DECODE_M_EXT_EN
        else if (f7 == 7'b0000001) begin
          dec.ill = 1'b0;
          dec.alu = {2'b10, f3};
        end
`endif
      end
      7'b0110111: begin
        dec.ill = 1'b0;
        dec.imm = imm_u;
        dec.lhs = 2'd2;
        dec.rhs = 2'd1;
        dec.wrf = 1'b1;
      end
      7'b0010111: begin
        dec.ill = 1'b0;
        dec.imm = imm_u;
        dec.lhs = 2'd1;
        dec.rhs = 2'd1;
        dec.wrf = 1'b1;
      end
      7'b1101111: begin
        dec.ill = 1'b0;
        dec.imm = imm_j;
        dec.lhs = 2'd1;
        dec.rhs = 2'd2;
        dec.jmp = 1'b1;
        dec.wrf = 1'b1;
      end
      7'b1100111: begin
        dec.ill = (f3 != 3'b000);
        dec.imm = imm_i;
        dec.lhs = 2'd1;
        dec.rhs = 2'd2;
        dec.jmp = 1'b1;
        dec.wrf = 1'b1;
      end
      7'b1100011: begin
        dec.ill = (f3 == 3'b010 || f3 == 3'b011);
        dec.imm = imm_b;
        dec.br  = 1'b1;
      end
      7'b0000011: begin
        dec.ill   = (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
        dec.imm   = imm_i;
        dec.rhs   = 2'd1;
        dec.rram  = 1'b1;
        dec.wrf   = 1'b1;
        dec.msize = f3;
      end
      7'b0100011: begin
        dec.ill   = (f3 > 3'b010);
        dec.imm   = imm_s;
        dec.rhs   = 2'd1;
        dec.wram  = 1'b1;
        dec.msize = f3;
      end
      default: ;
    endcase
    if (dec.ill) begin
      dec.wrf  = 1'b0;
      dec.wram = 1'b0;
      dec.rram = 1'b0;
      dec.br   = 1'b0;
      dec.jmp  = 1'b0;
    end
  end

  assign OutValid = (count != '0);
  assign InReady  = (count != CW'(DEPTH));
  assign push     = InValid & InReady & ~Flush;
  assign pop      = OutValid & OutReady;
  // When empty, replay whatever was on the outputs the cycle before.
  assign shown    = OutValid ? mem[rd_ptr] : last_q;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      IllegalCount <= '0;
      last_q       <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      last_q <= shown;
      if (Flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          mem[wr_ptr] <= dec;
          wr_ptr      <= wr_ptr + AW'(1);
        end
        if (pop)
          rd_ptr <= rd_ptr + AW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: ;
        endcase
        if (push && dec.ill && IllegalCount != '1)
          IllegalCount <= IllegalCount + CNT_WIDTH'(1);
      end
    end
  end

  assign OutPC                    = shown.pc;
  assign RD                       = shown.rd;
  assign RS1                      = shown.rs1;
  assign RS2                      = shown.rs2;
  assign DecodedImmediate         = shown.imm;
  assign LHSsource                = shown.lhs;
  assign RHSsource                = shown.rhs;
  assign ALUOperation             = shown.alu;
  assign WritesRegisterFile       = shown.wrf;
  assign WritesRam                = shown.wram;
  assign ReadsRam                 = shown.rram;
  assign IsBranch                 = shown.br;
  assign IsJump                   = shown.jmp;
  assign MemSize                  = shown.msize;
  assign InvalidInstructionSignal = shown.ill;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - scoreboard bench for decode_stage (DEPTH=2, CNT_WIDTH=2)
module tb_decode_stage;

  logic        Clock, Reset_n, Flush, InValid, InReady, OutValid, OutReady;
  logic [31:0] InInstruction, InPC, OutPC, DecodedImmediate;
  logic [4:0]  RD, RS1, RS2, ALUOperation;
  logic [1:0]  LHSsource, RHSsource, IllegalCount;
  logic        WritesRegisterFile, WritesRam, ReadsRam, IsBranch, IsJump;
  logic [2:0]  MemSize;
  logic        InvalidInstructionSignal;

  decode_stage #(.PC_WIDTH(32), .DEPTH(2), .CNT_WIDTH(2)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .Flush(Flush),
    .InValid(InValid), .InReady(InReady), .InInstruction(InInstruction), .InPC(InPC),
    .OutValid(OutValid), .OutReady(OutReady), .OutPC(OutPC),
    .RD(RD), .RS1(RS1), .RS2(RS2), .DecodedImmediate(DecodedImmediate),
    .LHSsource(LHSsource), .RHSsource(RHSsource), .ALUOperation(ALUOperation),
    .WritesRegisterFile(WritesRegisterFile), .WritesRam(WritesRam), .ReadsRam(ReadsRam),
    .IsBranch(IsBranch), .IsJump(IsJump), .MemSize(MemSize),
    .InvalidInstructionSignal(InvalidInstructionSignal), .IllegalCount(IllegalCount)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic [1:0]  lhs, rhs;
    logic [4:0]  alu;
    logic [4:0]  flags;   // {wrf, wram, rram, br, jmp}
    logic [2:0]  msize;
    logic        ill;
  } exp_t;

  exp_t        tbl [14];
  exp_t        sb [$];
  int          errors = 0;
  int          checks = 0;
  logic [1:0]  ill_model = 2'd0;
  logic [31:0] pc_next = 32'h1000;
  logic [64:0] obs_bundle;

  assign obs_bundle = {RD, RS1, RS2, DecodedImmediate, LHSsource, RHSsource, ALUOperation,
                       WritesRegisterFile, WritesRam, ReadsRam, IsBranch, IsJump,
                       MemSize, InvalidInstructionSignal};

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] instr, input logic [4:0] rd, rs1, rs2,
                              input logic [31:0] imm, input logic [1:0] lhs, rhs,
                              input logic [4:0] alu, flags, input logic [2:0] msize,
                              input logic ill);
    exp_t e;
    e = '0;
    e.instr = instr; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.imm = imm;
    e.lhs = lhs; e.rhs = rhs; e.alu = alu; e.flags = flags; e.msize = msize; e.ill = ill;
    return e;
  endfunction

  function automatic logic [64:0] pack_exp(input exp_t e);
    return {e.rd, e.rs1, e.rs2, e.imm, e.lhs, e.rhs, e.alu, e.flags, e.msize, e.ill};
  endfunction

  always begin
    @(negedge Clock);
    #1;
    if (Reset_n && OutValid && OutReady) begin
      if (sb.size() == 0) begin
        check("sb_underrun", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check($sformatf("bundle_%08h", e.instr), obs_bundle, pack_exp(e));
        check($sformatf("pc_%08h", e.instr), OutPC, e.pc);
      end
    end
  end

  task automatic send(input int idx);
    int   tries;
    exp_t e;
    e = tbl[idx];
    e.pc = pc_next;
    InValid = 1'b1;
    InInstruction = e.instr;
    InPC = e.pc;
    tries = 0;
    while (!InReady && tries < 50) begin
      @(negedge Clock);
      tries++;
    end
    if (!InReady) begin
      check("send_timeout", 0, 1);
      InValid = 1'b0;
      return;
    end
    sb.push_back(e);
    if (e.ill && ill_model != 2'd3) ill_model = ill_model + 2'd1;
    pc_next = pc_next + 32'd4;
    @(negedge Clock);
    InValid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || OutValid) && t < 50) begin
      @(negedge Clock);
      t++;
    end
    check("drain", (sb.size() == 0 && !OutValid), 1);
  endtask

  initial begin
    Reset_n = 1'b0; Flush = 1'b0; InValid = 1'b0; OutReady = 1'b0;
    InInstruction = '0; InPC = '0;

    tbl[0]  = mk(32'h00510093, 5'd1,  5'd2, 5'd5,  32'd5,        2'd0, 2'd1, 5'b00000, 5'b10000, 3'd0, 1'b0);
    tbl[1]  = mk(32'h00000000, 5'd0,  5'd0, 5'd0,  32'd0,        2'd0, 2'd0, 5'b00000, 5'b00000, 3'd0, 1'b1);
    tbl[2]  = mk(32'h402081B3, 5'd3,  5'd1, 5'd2,  32'd0,        2'd0, 2'd0, 5'b01000, 5'b10000, 3'd0, 1'b0);
    tbl[3]  = mk(32'h123452B7, 5'd5,  5'd8, 5'd3,  32'h12345000, 2'd2, 2'd1, 5'b00000, 5'b10000, 3'd0, 1'b0);
`ifdef DECODE_M_EXT_EN
    tbl[4]  = mk(32'h022081B3, 5'd3,  5'd1, 5'd2,  32'd0,        2'd0, 2'd0, 5'b10000, 5'b10000, 3'd0, 1'b0);
`else
    tbl[4]  = mk(32'h022081B3, 5'd3,  5'd1, 5'd2,  32'd0,        2'd0, 2'd0, 5'b00000, 5'b00000, 3'd0, 1'b1);
`endif
    tbl[5]  = mk(32'h008000EF, 5'd1,  5'd0, 5'd8,  32'd8,        2'd1, 2'd2, 5'b00000, 5'b10001, 3'd0, 1'b0);
    tbl[6]  = mk(32'hFE000EE3, 5'd29, 5'd0, 5'd0,  32'hFFFFFFFC, 2'd0, 2'd0, 5'b00000, 5'b00010, 3'd0, 1'b0);
    tbl[7]  = mk(32'hFFF3A303, 5'd6,  5'd7, 5'd31, 32'hFFFFFFFF, 2'd0, 2'd1, 5'b00000, 5'b10100, 3'd2, 1'b0);
    tbl[8]  = mk(32'h00532423, 5'd8,  5'd6, 5'd5,  32'd8,        2'd0, 2'd1, 5'b00000, 5'b01000, 3'd2, 1'b0);
    tbl[9]  = mk(32'h40209093, 5'd1,  5'd1, 5'd2,  32'h402,      2'd0, 2'd1, 5'b00001, 5'b00000, 3'd0, 1'b1);
    tbl[10] = mk(32'h4030D093, 5'd1,  5'd1, 5'd3,  32'h403,      2'd0, 2'd1, 5'b01101, 5'b10000, 3'd0, 1'b0);
    tbl[11] = mk(32'h00002063, 5'd0,  5'd0, 5'd0,  32'd0,        2'd0, 2'd0, 5'b00000, 5'b00000, 3'd0, 1'b1);
    tbl[12] = mk(32'h00001117, 5'd2,  5'd0, 5'd0,  32'h1000,     2'd1, 2'd1, 5'b00000, 5'b10000, 3'd0, 1'b0);
    tbl[13] = mk(32'h000280E7, 5'd1,  5'd5, 5'd0,  32'd0,        2'd1, 2'd2, 5'b00000, 5'b10001, 3'd0, 1'b0);

    #12;
    check("rst_outvalid", OutValid, 0);
    check("rst_inready", InReady, 1);
    check("rst_illcount", IllegalCount, 0);
    check("rst_bundle", obs_bundle, 0);
    check("rst_pc", OutPC, 0);
    @(negedge Clock);
    Reset_n = 1'b1;

    // single accept: valid one cycle later
    OutReady = 1'b1;
    send(0);
    check("latency_addi", OutValid, 1);
    drain();

    send(1);
    drain();
    check("illcount_one", IllegalCount, 1);

    for (int i = 2; i < 14; i++) send(i);
    drain();
    check("illcount_after_table", IllegalCount, ill_model);

    // backpressure with DEPTH=2
    OutReady = 1'b0;
    send(3);
    send(7);
    check("full_after_two", InReady, 0);
    fork
      send(8);
      begin
        repeat (3) begin
          @(negedge Clock);
          #2;
          check("held_inready", InReady, 0);
          check("held_head_rd", RD, 5);
        end
        @(negedge Clock);
        OutReady = 1'b1;
      end
    join
    drain();
    check("hold_after_drain", RD, 8);

    // reset mid-stream
    OutReady = 1'b0;
    send(2);
    send(3);
    #2;
    Reset_n = 1'b0;
    #1;
    check("midrst_outvalid", OutValid, 0);
    check("midrst_inready", InReady, 1);
    check("midrst_illcount", IllegalCount, 0);
    check("midrst_bundle", obs_bundle, 0);
    sb.delete();
    ill_model = 2'd0;
    @(negedge Clock);
    Reset_n = 1'b1;
    OutReady = 1'b1;
    send(0);
    check("latency_after_rst", OutValid, 1);
    drain();

    // flush with a simultaneous illegal push
    OutReady = 1'b0;
    send(0);
    send(2);
    Flush = 1'b1;
    InValid = 1'b1;
    InInstruction = 32'h00000000;
    @(negedge Clock);
    Flush = 1'b0;
    InValid = 1'b0;
    #2;
    check("flush_outvalid", OutValid, 0);
    check("flush_inready", InReady, 1);
    check("flush_illcount", IllegalCount, ill_model);
    check("flush_hold_rd", RD, 1);
    sb.delete();
    @(negedge Clock);

    // saturation of the 2-bit counter
    OutReady = 1'b1;
    send(1);
    send(11);
    send(9);
    send(1);
    send(1);
    drain();
    check("illcount_saturated", IllegalCount, 3);
    check("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
